// File: rtl/perf_pkg.sv
// perf_pkg: shared types and address map for the performance monitor.
// Imported by perf_counter and perf_event_monitor.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } perf_state_e;

  localparam int PERF_ADDR_CYCLES   = 0;
  localparam int PERF_ADDR_EVT_BASE = 1;

endpackage

// File: rtl/perf_counter.sv
// perf_counter: one counter with sticky overflow flag.
// PERF_SATURATE_EN selects saturation at all-ones instead of wrap.
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  // count up on inc; flag the first increment from all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
`ifdef PERF_SATURATE_EN
        cnt_q <= cnt_q;
`else
        cnt_q <= '0;
`endif
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_event_monitor.sv
// perf_event_monitor: cycle + event counters, limit halt, snapshot bank.
// Define PERF_SATURATE_EN for saturating counters (default wraps).
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS  = 4,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 30,
  parameter int ADDR_W      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  clear_i,
  input  logic                  snapshot_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [CNT_W-1:0]      rd_data_o,
  output logic [CNT_W-1:0]      cycle_o,
  output logic                  running_o,
  output logic                  limit_hit_o,
  output logic [NUM_EVENTS:0]   overflow_o
);

  localparam int NC = NUM_EVENTS + 1;
  localparam bit LIM_EN = (CYCLE_LIMIT != 0);
  localparam logic [CNT_W-1:0] LIM_M1 =
    CNT_W'(CYCLE_LIMIT - 1);

  perf_state_e      state_q, state_d;
  logic             run;
  logic [NC-1:0]    inc;
  logic [CNT_W-1:0] live   [NC];
  logic [CNT_W-1:0] shadow [NC];
  logic [CNT_W-1:0] rd_next;

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state: clear wins, limit beats a falling start
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start_i) state_d = RUN;
        RUN: begin
          if (LIM_EN && live[PERF_ADDR_CYCLES] == LIM_M1)
            state_d = HALT;
          else if (!start_i)
            state_d = IDLE;
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  assign run = (state_q == RUN);
  assign inc[PERF_ADDR_CYCLES] = run;

  for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_inc
    assign inc[PERF_ADDR_EVT_BASE+k] = run & event_i[k];
  end

  for (genvar i = 0; i < NC; i++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .inc_i (inc[i]),
      .cnt_o (live[i]),
      .ovf_o (overflow_o[i])
    );
  end

  // shadow bank: capture pre-increment live values; clear leaves it alone
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NC; i++) shadow[i] <= '0;
    end else if (snapshot_i) begin
      for (int i = 0; i < NC; i++) shadow[i] <= live[i];
    end
  end

  // read mux: unmapped addresses return zero
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NC; i++)
      if (rd_addr_i == ADDR_W'(i)) rd_next = shadow[i];
  end

  // registered read port
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_o <= '0;
    else       rd_data_o <= rd_next;
  end

  assign cycle_o     = live[PERF_ADDR_CYCLES];
  assign running_o   = run;
  assign limit_hit_o = (state_q == HALT);

endmodule

// File: tb/tb_perf_event_monitor.sv
// tb_perf_event_monitor: self-checking bench for perf_event_monitor.
// Second instance uses CNT_W=4, CYCLE_LIMIT=0 for wrap/saturate.
module tb_perf_event_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        snap = 1'b0;
  logic [3:0]  evt = '0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic [31:0] cyc;
  logic        running;
  logic        limit;
  logic [4:0]  ovf;

  logic        start_b = 1'b0;
  logic        clear_b = 1'b0;
  logic        snap_b = 1'b0;
  logic [3:0]  evt_b = '0;
  logic [3:0]  rd_addr_b = '0;
  logic [3:0]  rd_data_b;
  logic [3:0]  cyc_b;
  logic        running_b;
  logic        limit_b;
  logic [4:0]  ovf_b;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t     vec [8];
  logic [31:0] exp_q [$];
  logic [31:0] prev;
  int          n;

  always #5 clk = ~clk;

  perf_event_monitor dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .event_i     (evt),
    .clear_i     (clear),
    .snapshot_i  (snap),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .cycle_o     (cyc),
    .running_o   (running),
    .limit_hit_o (limit),
    .overflow_o  (ovf)
  );

  perf_event_monitor #(
    .CNT_W       (4),
    .CYCLE_LIMIT (0)
  ) dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start_b),
    .event_i     (evt_b),
    .clear_i     (clear_b),
    .snapshot_i  (snap_b),
    .rd_addr_i   (rd_addr_b),
    .rd_data_o   (rd_data_b),
    .cycle_o     (cyc_b),
    .running_o   (running_b),
    .limit_hit_o (limit_b),
    .overflow_o  (ovf_b)
  );

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [3:0] a,
                      input logic [31:0] e);
    vec[i].addr = a;
    vec[i].exp  = e;
  endtask

  task automatic run_reads(input int cnt);
    logic [31:0] e;
    for (int i = 0; i < cnt; i++) begin
      rd_addr = vec[i].addr;
      exp_q.push_back(vec[i].exp);
      if (i > 0) check("rd_latency", {32'd0, rd_data}, {32'd0, prev});
      step(1);
      e = exp_q.pop_front();
      check($sformatf("rd_addr%0d", vec[i].addr), {32'd0, rd_data}, {32'd0, e});
      prev = e;
    end
  endtask

  task automatic wait_halt();
    n = 0;
    while (!limit && n < 100) begin
      step(1);
      n++;
    end
  endtask

  task automatic do_snap();
    snap = 1'b1;
    step(1);
    snap = 1'b0;
  endtask

  initial begin
    // reset
    step(2);
    check("rst_cycle", cyc, 0);
    check("rst_running", running, 0);
    check("rst_limit", limit, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rd", rd_data, 0);
    rst = 1'b0;
    step(1);
    check("idle_cycle", cyc, 0);

    // limit scenario
    start = 1'b1;
    evt = 4'b0001;
    step(1);
    check("enter_run", running, 1);
    check("enter_nocount", cyc, 0);
    wait_halt();
    check("limit_steps", n, 30);
    check("limit_cycle", cyc, 30);
    check("limit_running", running, 0);
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      step(1);
    end
    check("halt_hold_cycle", cyc, 30);
    check("halt_hold_flag", limit, 1);
    do_snap();
    setv(0, 4'd0, 32'd30);
    setv(1, 4'd1, 32'd30);
    setv(2, 4'd2, 32'd0);
    setv(3, 4'd4, 32'd0);
    setv(4, 4'd5, 32'd0);
    setv(5, 4'd15, 32'd0);
    setv(6, 4'd1, 32'd30);
    run_reads(7);

    // pause scenario
    start = 1'b0;
    evt = '0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_idle", limit, 0);
    check("clear_cycle", cyc, 0);
    for (int i = 0; i < 16; i++) begin
      start = (i < 5) || (i >= 8 && i < 12);
      evt = (i % 2 == 1) ? 4'b0010 : 4'b0000;
      step(1);
    end
    start = 1'b0;
    evt = '0;
    check("pause_cycle", cyc, 9);
    check("pause_running", running, 0);
    do_snap();
    setv(0, 4'd0, 32'd9);
    setv(1, 4'd2, 32'd5);
    setv(2, 4'd1, 32'd0);
    run_reads(3);

    // snapshot coherency while counting
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    start = 1'b1;
    step(7);
    check("coh_pre", cyc, 6);
    do_snap();
    check("coh_live", cyc, 7);
    setv(0, 4'd0, 32'd6);
    setv(1, 4'd15, 32'd0);
    run_reads(2);

    // clear + snapshot priority
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    evt = 4'b1111;
    step(6);
    check("cp_pre", cyc, 5);
    clear = 1'b1;
    snap = 1'b1;
    step(1);
    clear = 1'b0;
    snap = 1'b0;
    start = 1'b0;
    evt = '0;
    check("cp_cycle", cyc, 0);
    check("cp_running", running, 0);
    check("cp_ovf", ovf, 0);
    for (int i = 0; i < 5; i++) setv(i, 4'(i), 32'd5);
    run_reads(5);
    check("cp_stay_idle", cyc, 0);

    // reset mid-run, then replay limit
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    start = 1'b1;
    evt = 4'b0001;
    step(11);
    check("mid_pre", cyc, 10);
    rd_addr = 4'd2;
    step(1);
    rst = 1'b1;
    step(1);
    check("mid_cycle", cyc, 0);
    check("mid_running", running, 0);
    check("mid_limit", limit, 0);
    check("mid_ovf", ovf, 0);
    check("mid_rd", rd_data, 0);
    rst = 1'b0;
    start = 1'b0;
    setv(0, 4'd0, 32'd0);
    setv(1, 4'd2, 32'd0);
    run_reads(2);
    start = 1'b1;
    step(1);
    wait_halt();
    check("replay_steps", n, 30);
    check("replay_cycle", cyc, 30);
    do_snap();
    setv(0, 4'd1, 32'd30);
    run_reads(1);
    start = 1'b0;
    evt = '0;

    // narrow counter wrap / saturate
    start_b = 1'b1;
    step(1);
    step(15);
    check("b_at_max", {60'd0, cyc_b}, 15);
    check("b_no_ovf", {59'd0, ovf_b}, 0);
    step(2);
`ifdef PERF_SATURATE_EN
    check("b_sat_cycle", {60'd0, cyc_b}, 15);
`else
    check("b_wrap_cycle", {60'd0, cyc_b}, 1);
`endif
    check("b_ovf", {63'd0, ovf_b[0]}, 1);
    check("b_ovf_others", {60'd0, ovf_b[4:1]}, 0);
    check("b_no_limit", {63'd0, limit_b}, 0);
    start_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
